// File: rtl/rx_frame_check.sv
// UART-style receive frame checker: start/data/parity/stop framing,
// parity and stop-bit checking, saturating error counters.
// Ports:
//   CLK, RST          clock, async active-high reset
//   sample_valid      one-cycle strobe per mid-bit sample
//   sampled_bit       line value when sample_valid=1
//   PAR_EN, PAR_MODE  parity enable, mode (even/odd/mark/space)
//   STOP_BITS         0 = one stop bit, 1 = two
//   err_clr           sync clear of both error counters
//   P_DATA            received data word (LSB first on line)
//   frame_valid       one-cycle completion pulse
//   par_err, stp_err  error flags of the reported frame
//   busy              high outside IDLE
//   par_err_cnt       saturating parity error count
//   stp_err_cnt       saturating stop error count
module rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sample_valid,
  input  logic                  sampled_bit,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_MODE,
  input  logic                  STOP_BITS,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  frame_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, DATA, PARITY, STOP1, STOP2
  } state_t;

  state_t state, state_nx;

  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  run_par;
  logic                  par_flag;
  logic                  stp_flag;
  logic                  cfg_par_en;
  logic [1:0]            cfg_mode;
  logic                  cfg_stop2;

  logic start, shift, par_smp, stop_smp, done;
  logic exp_par, par_nx, stp_nx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (sample_valid) begin
      unique case (state)
        IDLE:   if (!sampled_bit) state_nx = DATA;
        DATA:   if (bit_cnt == LAST)
                  state_nx = cfg_par_en ? PARITY : STOP1;
        PARITY: state_nx = STOP1;
        STOP1:  state_nx = cfg_stop2 ? STOP2 : IDLE;
        STOP2:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    start    = 1'b0;
    shift    = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    done     = 1'b0;
    if (sample_valid) begin
      unique case (state)
        IDLE:   start = !sampled_bit;
        DATA:   shift = 1'b1;
        PARITY: par_smp = 1'b1;
        STOP1:  begin
          stop_smp = 1'b1;
          done     = !cfg_stop2;
        end
        STOP2:  begin
          stop_smp = 1'b1;
          done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (cfg_mode)
      2'b00:   exp_par = run_par;
      2'b01:   exp_par = ~run_par;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  // Flags as they stand including the final stop sample.
  assign par_nx = par_flag;
  assign stp_nx = stp_flag | ~sampled_bit;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      run_par     <= 1'b0;
      par_flag    <= 1'b0;
      stp_flag    <= 1'b0;
      cfg_par_en  <= 1'b0;
      cfg_mode    <= 2'b00;
      cfg_stop2   <= 1'b0;
      P_DATA      <= '0;
      frame_valid <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      frame_valid <= done;
      if (start) begin
        cfg_par_en <= PAR_EN;
        cfg_mode   <= PAR_MODE;
        cfg_stop2  <= STOP_BITS;
        bit_cnt    <= '0;
        run_par    <= 1'b0;
        par_flag   <= 1'b0;
        stp_flag   <= 1'b0;
      end
      if (shift) begin
        shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
        run_par <= run_par ^ sampled_bit;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_smp)
        par_flag <= (sampled_bit != exp_par);
      if (stop_smp && !sampled_bit)
        stp_flag <= 1'b1;
      if (done) begin
        P_DATA  <= shreg;
        par_err <= par_nx;
        stp_err <= stp_nx;
      end
    end
  end

  // Clear has priority over a coincident increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (err_clr) begin
      par_err_cnt <= '0;
      stp_err_cnt <= '0;
    end else if (done) begin
      if (par_nx && par_err_cnt != '1)
        par_err_cnt <= par_err_cnt + 1'b1;
      if (stp_nx && stp_err_cnt != '1)
        stp_err_cnt <= stp_err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_frame_check.sv
// Randomized bench for rx_frame_check against a frame-level model.
// Counters are built 2 bits wide so saturation is reached quickly.
module tb_rx_frame_check;

  localparam int W    = 8;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          CLK = 1'b0;
  logic          RST;
  logic          sample_valid;
  logic          sampled_bit;
  logic          PAR_EN;
  logic [1:0]    PAR_MODE;
  logic          STOP_BITS;
  logic          err_clr;
  logic [W-1:0]  P_DATA;
  logic          frame_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;
  logic [CW-1:0] par_err_cnt;
  logic [CW-1:0] stp_err_cnt;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0;
  int fv_exp = 0;
  int m_par = 0;
  int m_stp = 0;

  always #5 CLK = ~CLK;

  rx_frame_check #(
    .DATA_WIDTH(W),
    .CNT_WIDTH (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .sample_valid(sample_valid),
    .sampled_bit (sampled_bit),
    .PAR_EN      (PAR_EN),
    .PAR_MODE    (PAR_MODE),
    .STOP_BITS   (STOP_BITS),
    .err_clr     (err_clr),
    .P_DATA      (P_DATA),
    .frame_valid (frame_valid),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .busy        (busy),
    .par_err_cnt (par_err_cnt),
    .stp_err_cnt (stp_err_cnt)
  );

  always @(negedge CLK)
    if (frame_valid) fv_seen <= fv_seen + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    sample_valid = 1'b0;
    repeat (n) tick;
  endtask

  task automatic idle_ones(input int n);
    repeat (n) begin
      sample_valid = 1'b1;
      sampled_bit  = 1'b1;
      tick;
    end
    sample_valid = 1'b0;
  endtask

  task automatic clr_cnt;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    m_par = 0;
    m_stp = 0;
    chk("clr_par", 32'(par_err_cnt), 0);
    chk("clr_stp", 32'(stp_err_cnt), 0);
  endtask

  task automatic send_frame(input logic [W-1:0] d,
                            input logic pe,
                            input logic [1:0] pm,
                            input logic sb2,
                            input logic pbit,
                            input logic s1,
                            input logic s2,
                            input logic clr,
                            input int maxgap);
    bit q[$];
    logic ep, pe_x, se_x;
    q.push_back(1'b0);
    for (int i = 0; i < W; i++) q.push_back(d[i]);
    if (pe) q.push_back(pbit);
    q.push_back(s1);
    if (sb2) q.push_back(s2);
    PAR_EN = pe;
    PAR_MODE = pm;
    STOP_BITS = sb2;
    foreach (q[i]) begin
      sample_valid = 1'b1;
      sampled_bit  = q[i];
      err_clr      = clr && (i == q.size() - 1);
      tick;
      sample_valid = 1'b0;
      err_clr      = 1'b0;
      sampled_bit  = 1'($urandom);
      if (i == 0) begin
        PAR_EN    = 1'($urandom);
        PAR_MODE  = 2'($urandom);
        STOP_BITS = 1'($urandom);
      end
      if (i != q.size() - 1)
        repeat ($urandom_range(maxgap, 0)) tick;
      if (i == 1) chk("busy_mid", 32'(busy), 1);
    end
    case (pm)
      2'd0:    ep = ^d;
      2'd1:    ep = ~^d;
      2'd2:    ep = 1'b1;
      default: ep = 1'b0;
    endcase
    pe_x = pe && (pbit != ep);
    se_x = !s1 || (sb2 && !s2);
    if (clr) begin
      m_par = 0;
      m_stp = 0;
    end else begin
      if (pe_x && m_par < CMAX) m_par++;
      if (se_x && m_stp < CMAX) m_stp++;
    end
    fv_exp++;
    chk("frame_valid", 32'(frame_valid), 1);
    chk("fv_count", fv_seen, fv_exp);
    chk("p_data", 32'(P_DATA), 32'(d));
    chk("par_err", 32'(par_err), 32'(pe_x));
    chk("stp_err", 32'(stp_err), 32'(se_x));
    chk("busy_end", 32'(busy), 0);
    chk("par_cnt", 32'(par_err_cnt), m_par);
    chk("stp_cnt", 32'(stp_err_cnt), m_stp);
  endtask

  initial begin
    logic [7:0] part;
    RST = 1'b1;
    sample_valid = 1'b0;
    sampled_bit = 1'b1;
    PAR_EN = 1'b0;
    PAR_MODE = 2'b00;
    STOP_BITS = 1'b0;
    err_clr = 1'b0;
    #12;
    chk("rst_fv", 32'(frame_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(P_DATA), 0);
    chk("rst_perr", 32'(par_err), 0);
    chk("rst_serr", 32'(stp_err), 0);
    chk("rst_pcnt", 32'(par_err_cnt), 0);
    chk("rst_scnt", 32'(stp_err_cnt), 0);
    tick;
    RST = 1'b0;
    idle(2);
    idle_ones(3);
    chk("idle_busy", 32'(busy), 0);

    send_frame(8'hA5, 0, 2'd0, 0, 0, 1, 1, 0, 0);
    idle(2);
    send_frame(8'hA5, 1, 2'd0, 0, 1, 1, 1, 0, 1);
    idle(2);
    send_frame(8'hA5, 1, 2'd1, 0, 1, 1, 1, 0, 1);
    idle(2);
    clr_cnt();
    send_frame(8'h5A, 1, 2'd2, 0, 0, 1, 1, 0, 1);
    idle(1);
    send_frame(8'h33, 1, 2'd3, 0, 1, 1, 1, 0, 1);
    idle(1);
    send_frame(8'hC3, 0, 2'd0, 1, 0, 1, 0, 0, 1);
    idle(2);

    clr_cnt();
    for (int k = 0; k < 5; k++) begin
      send_frame(8'(k * 37), 1, 2'd2, 0, 0, 1, 1, 0, 1);
      idle(1);
    end
    send_frame(8'h77, 1, 2'd2, 0, 0, 1, 1, 1, 1);
    idle(2);

    part = 8'h3C;
    PAR_EN = 1'b0;
    STOP_BITS = 1'b0;
    sample_valid = 1'b1;
    sampled_bit = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      sampled_bit = part[i];
      tick;
    end
    sample_valid = 1'b0;
    RST = 1'b1;
    #1;
    m_par = 0;
    m_stp = 0;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_fv", 32'(frame_valid), 0);
    chk("mrst_pcnt", 32'(par_err_cnt), 0);
    tick;
    RST = 1'b0;
    idle_ones(4);
    chk("mrst_idle", 32'(busy), 0);
    idle(2);
    chk("mrst_nofv", fv_seen, fv_exp);
    send_frame(8'h3C, 0, 2'd0, 0, 0, 1, 1, 0, 0);
    idle(2);

    send_frame(8'h12, 0, 2'd0, 0, 0, 1, 1, 0, 0);
    send_frame(8'h34, 0, 2'd0, 0, 0, 1, 1, 0, 0);
    idle(2);

    for (int k = 0; k < 60; k++) begin
      send_frame(8'($urandom), 1'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom),
                 $urandom_range(3, 0) != 0,
                 $urandom_range(3, 0) != 0,
                 $urandom_range(9, 0) == 0, 2);
      if ($urandom_range(2, 0) != 0) begin
        idle($urandom_range(3, 1));
        if ($urandom_range(1, 0) != 0)
          idle_ones($urandom_range(2, 1));
      end
    end
    idle(3);
    chk("final_fv", fv_seen, fv_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
